// File: rtl/winograd_tile_reader.sv
// Gathers overlapping 4x4 stride-2 tiles for the Winograd F(2x2,3x3) input transform. Define WINO_ZERO_PAD_EN to add a 1-element zero border.
// Latency: first tile is valid 17 edges after io_start is sampled. With ready held high, one tile is produced every 18 cycles.
// Backpressure: while io_tile_ready is low, the tile is held stable and no RAM reads are issued.
`timescale 1ns/1ps
module winograd_tile_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int MAP_W  = 32,
  parameter int MAP_H  = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_start,
  output logic                 io_busy,
  output logic                 io_done,
  output logic [ADDR_W-1:0]    io_ram_addr,
  output logic                 io_ram_en,
  input  logic [DATA_W-1:0]    io_ram_data,
  output logic                 io_tile_valid,
  input  logic                 io_tile_ready,
  output logic [16*DATA_W-1:0] io_tile_data,
  output logic                 io_tile_last
);
`ifdef WINO_ZERO_PAD_EN
  localparam int TX = MAP_W / 2;
  localparam int TY = MAP_H / 2;
`else
  localparam int TX = (MAP_W - 4) / 2 + 1;
  localparam int TY = (MAP_H - 4) / 2 + 1;
`endif
  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0]    MAP_W_V = AW1'(MAP_W);
  localparam logic [ADDR_W-1:0] TX_LAST = ADDR_W'(TX - 1);
  localparam logic [ADDR_W-1:0] TY_LAST = ADDR_W'(TY - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t               state, state_nxt;
  logic [4:0]           cnt;
  logic [ADDR_W-1:0]    tx, ty;
  logic                 cap_vld, cap_zero;
  logic [3:0]           cap_idx;
  logic [16*DATA_W-1:0] tile_q;
  logic                 issue, in_map, last_tile, hs;
  logic [AW1-1:0]       row_p, col_p, row, col;

  // cnt[3:2] is the tile row r and cnt[1:0] is the tile column c of the element being issued
  assign row_p = {ty, 1'b0} + AW1'(cnt[3:2]);
  assign col_p = {tx, 1'b0} + AW1'(cnt[1:0]);
`ifdef WINO_ZERO_PAD_EN
  localparam logic [AW1-1:0] MAP_H_V = AW1'(MAP_H);
  // row_p/col_p are coordinates in the bordered map; in-map elements shift back by one
  assign in_map = (row_p != '0) && (row_p <= MAP_H_V) && (col_p != '0) && (col_p <= MAP_W_V);
  assign row    = row_p - AW1'(1);
  assign col    = col_p - AW1'(1);
`else
  assign in_map = 1'b1;
  assign row    = row_p;
  assign col    = col_p;
`endif

  assign last_tile    = (tx == TX_LAST) && (ty == TY_LAST);
  assign hs           = io_tile_valid & io_tile_ready;
  assign io_ram_en    = issue & in_map;
  assign io_ram_addr  = io_ram_en ? ADDR_W'(row * MAP_W_V + col) : '0;
  assign io_tile_data = tile_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    issue         = 1'b0;
    io_busy       = 1'b0;
    io_done       = 1'b0;
    io_tile_valid = 1'b0;
    io_tile_last  = 1'b0;
    case (state)
      IDLE: if (io_start) state_nxt = FETCH;
      FETCH: begin
        io_busy = 1'b1;
        issue   = (cnt < 5'd16);
        // cycle 16 only waits for the capture of element 15
        if (cnt == 5'd16) state_nxt = HOLD;
      end
      HOLD: begin
        io_busy       = 1'b1;
        io_tile_valid = 1'b1;
        io_tile_last  = last_tile;
        if (io_tile_ready) state_nxt = last_tile ? DONE : FETCH;
      end
      DONE: begin
        io_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      tx       <= '0;
      ty       <= '0;
      cap_vld  <= 1'b0;
      cap_zero <= 1'b0;
      cap_idx  <= '0;
      tile_q   <= '0;
    end else begin
      // the RAM returns data one cycle after issue, so the slot index and pad flag are delayed to match
      cap_vld  <= issue;
      cap_idx  <= cnt[3:0];
      cap_zero <= ~in_map;
      if (cap_vld) tile_q[cap_idx*DATA_W +: DATA_W] <= cap_zero ? '0 : io_ram_data;
      if (state == FETCH) cnt <= (cnt == 5'd16) ? 5'd0 : cnt + 5'd1;
      if (hs) begin
        if (last_tile) begin
          tx <= '0;
          ty <= '0;
        end else if (tx == TX_LAST) begin
          tx <= '0;
          ty <= ty + 1'b1;
        end else begin
          tx <= tx + 1'b1;
        end
      end
    end
  end
endmodule
